button_value_source: RTL and testbench

- Upstream stage of the switch-to-display path. Produces the 4-bit binary value that the binary-to-BCD decoder consumes, which then drives the two-digit display controller.
- Replaces raw switch input with a debounced push-button up/down counter. The counter can also be loaded from the switches.
- One instance per board; sits between the board buttons/switches and the decoder's 4-bit input.

---
 rtl/button_value_source.sv | 141 ++++++++++++++
 tb/tb_button_value_source.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_value_source.sv
// rtl/button_value_source.sv - debounced inc/dec/load push-button counter feeding the BCD decoder
module button_value_source #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_VALUE       = 15,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_load,
  input  logic [3:0] sw,
  output logic [3:0] value,
  output logic       value_changed
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]        MAX_V    = 4'(MAX_VALUE);

  // Button index map: 0 = inc, 1 = dec, 2 = load.
  localparam int BTN_INC  = 0;
  localparam int BTN_DEC  = 1;
  localparam int BTN_LOAD = 2;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  logic [2:0]       raw_pressed;
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  db_state_e        state_q [3];
  db_state_e        state_d [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       evt_q, evt_d;
  logic [3:0]       value_q, value_d;
  logic             changed_q, changed_d;

  // Normalise every button to pressed = 1 before it enters the synchronizer.
  assign raw_pressed = BTN_ACTIVE_LOW ? ~{btn_load, btn_dec, btn_inc}
                                      :  {btn_load, btn_dec, btn_inc};

  // Two-flop synchronizer chain for the asynchronous button inputs.
  always_comb begin
    sync1_d = raw_pressed;
    sync2_d = sync1_q;
  end

  // Per-button debounce: a level change needs DEBOUNCE_CYCLES stable cycles in a WAIT state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = '0;
    for (int b = 0; b < 3; b++) begin
      case (state_q[b])
        RELEASED: begin
          if (sync2_q[b]) begin
            state_d[b] = PRESS_WAIT;
            cnt_d[b]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[b]) begin
            state_d[b] = RELEASED;
          end else if (cnt_q[b] == CNT_LAST) begin
            state_d[b] = PRESSED;
            evt_d[b]   = 1'b1;
          end else begin
            cnt_d[b] = cnt_q[b] + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2_q[b]) begin
            state_d[b] = RELEASE_WAIT;
            cnt_d[b]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q[b]) begin
            state_d[b] = PRESSED;
          end else if (cnt_q[b] == CNT_LAST) begin
            state_d[b] = RELEASED;
          end else begin
            cnt_d[b] = cnt_q[b] + 1'b1;
          end
        end
        default: state_d[b] = RELEASED;
      endcase
    end
  end

  // Count update from the press events: load wins, inc+dec cancel, otherwise wrap at MAX_VALUE.
  always_comb begin
    value_d = value_q;
    if (evt_q[BTN_LOAD]) begin
      value_d = (sw > MAX_V) ? MAX_V : sw;
    end else if (evt_q[BTN_INC] && evt_q[BTN_DEC]) begin
      value_d = value_q;
    end else if (evt_q[BTN_INC]) begin
      value_d = (value_q == MAX_V) ? 4'd0 : value_q + 4'd1;
    end else if (evt_q[BTN_DEC]) begin
      value_d = (value_q == 4'd0) ? MAX_V : value_q - 4'd1;
    end
    changed_d = (value_d != value_q);
  end

  // State registers; everything resets to the released / zero condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      evt_q     <= '0;
      value_q   <= '0;
      changed_q <= 1'b0;
      for (int b = 0; b < 3; b++) begin
        state_q[b] <= RELEASED;
        cnt_q[b]   <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      evt_q     <= evt_d;
      value_q   <= value_d;
      changed_q <= changed_d;
      for (int b = 0; b < 3; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  assign value         = value_q;
  assign value_changed = changed_q;

endmodule

// File: tb/tb_button_value_source.sv
// tb/tb_button_value_source.sv - self-checking bench for button_value_source with a run-length model
module tb_button_value_source;

  localparam int DEB = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       btn_inc  = 1'b1;
  logic       btn_dec  = 1'b1;
  logic       btn_load = 1'b1;
  logic [3:0] sw       = 4'd0;
  logic [3:0] value_a, value_b;
  logic       chg_a, chg_b;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int last_pulse_a = -1;

  always #5 clk = ~clk;

  button_value_source #(.DEBOUNCE_CYCLES(DEB), .MAX_VALUE(15), .BTN_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_load(btn_load),
    .sw(sw), .value(value_a), .value_changed(chg_a)
  );

  button_value_source #(.DEBOUNCE_CYCLES(DEB), .MAX_VALUE(9), .BTN_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_load(btn_load),
    .sw(sw), .value(value_b), .value_changed(chg_b)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle++;

  // Reference model: synced level is the raw press delayed two edges; a debounced
  // level flips after DEB+1 consecutive equal synced samples; events act one edge later.
  logic [3:0] m_val [2];
  bit         m_chg [2];
  bit         p1 [3];
  bit         p2 [3];
  bit         lvl [3];
  bit         runv [3];
  bit         pend [3];
  int         runl [3];

  always @(posedge clk or negedge rst_n) begin : model
    bit         s;
    int         mx;
    logic [3:0] old_v;
    logic [3:0] nv;
    logic [2:0] raw;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_val[k] = 4'd0;
        m_chg[k] = 1'b0;
      end
      for (int b = 0; b < 3; b++) begin
        p1[b] = 0; p2[b] = 0; lvl[b] = 0; runv[b] = 0; runl[b] = 0; pend[b] = 0;
      end
    end else begin
      raw = ~{btn_load, btn_dec, btn_inc};
      for (int k = 0; k < 2; k++) begin
        mx    = (k == 0) ? 15 : 9;
        old_v = m_val[k];
        nv    = old_v;
        if (pend[2])                nv = (int'(sw) > mx) ? 4'(mx) : sw;
        else if (pend[0] && pend[1]) nv = old_v;
        else if (pend[0])           nv = (int'(old_v) == mx) ? 4'd0 : old_v + 4'd1;
        else if (pend[1])           nv = (old_v == 4'd0) ? 4'(mx) : old_v - 4'd1;
        m_chg[k] = (nv != old_v);
        m_val[k] = nv;
      end
      for (int b = 0; b < 3; b++) begin
        s = p2[b];
        if (s == runv[b]) begin
          if (runl[b] < 1000) runl[b]++;
        end else begin
          runv[b] = s;
          runl[b] = 1;
        end
        pend[b] = 0;
        if (s != lvl[b] && runl[b] >= DEB + 1) begin
          lvl[b]  = s;
          pend[b] = s;
        end
        p2[b] = p1[b];
        p1[b] = raw[b];
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always begin
    @(posedge clk);
    #2;
    check("value_a", int'(value_a), int'(m_val[0]));
    check("changed_a", int'(chg_a), int'(m_chg[0]));
    check("value_b", int'(value_b), int'(m_val[1]));
    check("changed_b", int'(chg_b), int'(m_chg[1]));
    if (chg_a) begin
      pulses_a++;
      last_pulse_a = cycle;
    end
    if (chg_b) pulses_b++;
  end

  // mask bit 0 = inc, 1 = dec, 2 = load
  task automatic press(input logic [2:0] m);
    @(negedge clk);
    if (m[0]) btn_inc  = 1'b0;
    if (m[1]) btn_dec  = 1'b0;
    if (m[2]) btn_load = 1'b0;
    repeat (10) @(negedge clk);
    btn_inc  = 1'b1;
    btn_dec  = 1'b1;
    btn_load = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int p0;
    int pb;
    int t_last;
    t_last = 0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_value", int'(value_a), 0);
    check("reset_changed", int'(chg_a), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Bouncy increment press, then a long hold.
    p0 = pulses_a;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn_inc = (((i / 2) % 2) == 0) ? 1'b0 : 1'b1;
      if (i == 8) t_last = cycle;
    end
    repeat (100) @(negedge clk);
    check("bounce_latency_ok", int'((last_pulse_a - t_last) >= 6 && (last_pulse_a - t_last) <= 8), 1);
    btn_inc = 1'b1;
    repeat (12) @(negedge clk);
    check("bounce_value", int'(value_a), 1);
    check("bounce_pulses", pulses_a - p0, 1);

    // Wrap at 15 and decrement from 0.
    repeat (14) press(3'b001);
    check("inc_to_15", int'(value_a), 15);
    p0 = pulses_a;
    press(3'b001);
    check("wrap_to_0", int'(value_a), 0);
    check("wrap_pulse", pulses_a - p0, 1);
    press(3'b010);
    check("dec_wrap_15", int'(value_a), 15);
    check("dec_wrap_b", int'(value_b), 5);

    // Load, repeated load, saturation in the MAX_VALUE=9 instance.
    sw = 4'd9;
    p0 = pulses_a;
    press(3'b100);
    check("load_9", int'(value_a), 9);
    check("load_9_pulse", pulses_a - p0, 1);
    p0 = pulses_a;
    press(3'b100);
    check("reload_9", int'(value_a), 9);
    check("reload_no_pulse", pulses_a - p0, 0);
    sw = 4'd12;
    pb = pulses_b;
    press(3'b100);
    check("load_12_a", int'(value_a), 12);
    check("load_12_sat_b", int'(value_b), 9);
    check("load_sat_no_pulse_b", pulses_b - pb, 0);

    // Simultaneous presses.
    p0 = pulses_a;
    press(3'b011);
    check("incdec_value", int'(value_a), 12);
    check("incdec_no_pulse", pulses_a - p0, 0);
    sw = 4'd3;
    press(3'b101);
    check("load_inc_a", int'(value_a), 3);
    check("load_inc_b", int'(value_b), 3);

    // Reset two cycles into the dec press-wait, button held through release.
    sw = 4'd5;
    press(3'b100);
    check("preload_5", int'(value_a), 5);
    @(negedge clk);
    btn_dec = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_a", int'(value_a), 0);
    check("midreset_b", int'(value_b), 0);
    p0 = pulses_a;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("held_dec_a", int'(value_a), 15);
    check("held_dec_b", int'(value_b), 9);
    check("held_dec_pulses", pulses_a - p0, 1);
    btn_dec = 1'b1;
    repeat (12) @(negedge clk);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_value", int'(value_a), 0);
    check("async_changed", int'(chg_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) btn_inc  = ~btn_inc;
      if ($urandom_range(0, 7) == 0) btn_dec  = ~btn_dec;
      if ($urandom_range(0, 7) == 0) btn_load = ~btn_load;
      sw    = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    rst_n    = 1'b1;
    btn_inc  = 1'b1;
    btn_dec  = 1'b1;
    btn_load = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
